// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. It assembles WIDTH-bit words from a qualified bit stream
// into a held output register with a valid/ready handshake, and flags a sticky overrun.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [15:0]      word_count
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      wc_q, wc_d;

  logic [WIDTH-1:0] base, shifted;
  logic             last_bit, complete, load, drop;

  always_comb begin
    // A frame restart drops the partial word before the current bit enters.
    base = frame_start ? '0 : sr_q;
    if (MSB_FIRST) begin
      shifted = {base[WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, base[WIDTH-1:1]};
    end
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    complete = in_valid & ~frame_start & last_bit;
    load     = complete & (~valid_q | out_ready);
    drop     = complete & valid_q & ~out_ready;
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    po_d    = po_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    wc_d    = wc_q;

    if (in_valid) begin
      sr_d = shifted;
      if (complete) begin
        cnt_d = '0;
      end else if (frame_start) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (frame_start) begin
      sr_d  = '0;
      cnt_d = '0;
    end

    if (load) begin
      po_d    = shifted;
      valid_d = 1'b1;
      wc_d    = wc_q + 16'd1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Set wins over clear when both happen on one edge.
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      wc_q    <= wc_d;
    end
  end

  assign parallel_out = po_q;
  assign out_valid    = valid_q;
  assign overrun      = ovr_q;
  assign bit_cnt      = cnt_q;
  assign word_count   = wc_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are compared
// every cycle against a bit-list reference model, plus directed literal checks.
module tb_sipo_deserializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst, serial_in, in_valid, frame_start, out_ready, clr_ovr;
  logic [W-1:0] po0, po1;
  logic v0, v1, o0, o1;
  logic [2:0] bc0, bc1;
  logic [15:0] wc0, wc1;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_ovr(clr_ovr),
    .parallel_out(po0), .out_valid(v0), .overrun(o0), .bit_cnt(bc0), .word_count(wc0)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_ovr(clr_ovr),
    .parallel_out(po1), .out_valid(v1), .overrun(o1), .bit_cnt(bc1), .word_count(wc1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of bits of the partial word, and the held output state.
  bit        mbits [W];
  int        mcnt;
  bit [W-1:0] mpo0, mpo1;
  bit        mvalid, movr;
  int        mwc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcnt = 0; mpo0 = '0; mpo1 = '0; mvalid = 0; movr = 0; mwc = 0;
    for (int k = 0; k < W; k++) mbits[k] = 0;
  endtask

  task automatic model_edge();
    bit completed;
    completed = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (frame_start) mcnt = 0;
    if (in_valid) begin
      mbits[mcnt] = serial_in;
      mcnt++;
      if (mcnt == W) begin
        completed = 1;
        mcnt = 0;
      end
    end
    if (clr_ovr) movr = 0;
    if (completed) begin
      if (!mvalid || out_ready) begin
        for (int k = 0; k < W; k++) begin
          mpo0[k]       = mbits[k];
          mpo1[W-1-k]   = mbits[k];
        end
        mvalid = 1;
        mwc = (mwc + 1) % 65536;
      end else begin
        movr = 1;
      end
    end else if (mvalid && out_ready) begin
      mvalid = 0;
    end
  endtask

  task automatic compare_all();
    chk("po_lsb", 32'(po0), 32'(mpo0));
    chk("po_msb", 32'(po1), 32'(mpo1));
    chk("valid", 32'({v1, v0}), 32'({mvalid, mvalid}));
    chk("overrun", 32'({o1, o0}), 32'({movr, movr}));
    chk("bit_cnt", 32'({bc1, bc0}), 32'({3'(mcnt), 3'(mcnt)}));
    chk("word_count", 32'({wc1, wc0}), {16'(mwc), 16'(mwc)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic b, input logic iv, input logic fs, input logic rdy,
                       input logic clr);
    serial_in = b; in_valid = iv; frame_start = fs; out_ready = rdy; clr_ovr = clr;
    step();
  endtask

  // Sends a word LSB-first in bit order (bit k of w is the k-th bit on the wire).
  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int k = 0; k < W; k++) drive(w[k], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_po", 32'(po0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_bitcnt", 32'(bc0), 32'h0);
    chk("rst_wc", 32'(wc0), 32'h0);
    compare_all();
    #2;
    rst = 1'b1;
  endtask

  int wc_ref;

  initial begin
    rst = 1'b0; serial_in = 0; in_valid = 0; frame_start = 0; out_ready = 0; clr_ovr = 0;
    model_reset();
    #1;
    chk("init_po", 32'(po0), 32'h0);
    chk("init_ovr", 32'(o0), 32'h0);
    step();
    #2 rst = 1'b1;

    // Basic word, both bit orders.
    send_word(8'h4D, 1'b1);
    chk("word1_lsb", 32'(po0), 32'h4D);
    chk("word1_msb", 32'(po1), 32'hB2);
    chk("word1_valid", 32'(v0), 32'h1);
    chk("word1_wc", 32'(wc0), 32'd1);

    // Gapped bits.
    for (int k = 0; k < W; k++) begin
      drive(k == 0 || k == 2 || k == 3 || k == 6, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int g = 0; g < 3; g++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k == 2) chk("gap_bitcnt", 32'(bc0), 32'd3);
    end
    chk("gap_po", 32'(po0), 32'h4D);
    chk("gap_wc", 32'(wc0), 32'd2);

    // Overrun: three words with no consumer.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wc_ref = wc0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    chk("ovr_po", 32'(po0), 32'h11);
    chk("ovr_flag", 32'(o0), 32'h1);
    chk("ovr_wc", 32'(wc0), 32'(wc_ref + 1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovr", 32'(o0), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("consume", 32'(v0), 32'h0);

    // Frame restart after a 5-bit partial.
    wc_ref = wc0;
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fs_bitcnt", 32'(bc0), 32'd1);
    for (int k = 1; k < W; k++) drive(((8'hA5 >> k) & 1) != 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fs_po", 32'(po0), 32'hA5);
    chk("fs_wc", 32'(wc0), 32'(wc_ref + 1));

    // Consume and complete on the same edge.
    for (int k = 0; k < W - 1; k++) drive(((8'h3C >> k) & 1) != 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("cc_po", 32'(po0), 32'h3C);
    chk("cc_valid", 32'(v0), 32'h1);
    chk("cc_ovr", 32'(o0), 32'h0);
    chk("cc_wc", 32'(wc0), 32'(wc_ref + 2));

    // Asynchronous reset mid-word.
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_bitcnt", 32'(bc0), 32'd4);
    async_reset();
    send_word(8'h96, 1'b1);
    chk("post_rst_po", 32'(po0), 32'h96);
    chk("post_rst_wc", 32'(wc0), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      if (i == 1500) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
